// File: rtl/idu_gpr_file_sb.sv
// Decode-stage GPR file with multi-port read/write, optional write bypass
// and a per-register saturating pending-write scoreboard for RAW detection.
module idu_gpr_file_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG),
    parameter int NRP    = 2,
    parameter int NWP    = 2,
    parameter int CNTW   = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_ready,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic [NWP-1:0]      wr_en,
    input  logic [NWP*AW-1:0]   wr_addr,
    input  logic [NWP*XLEN-1:0] wr_data,
    input  logic                flush,
    output logic                pend_any
);

    localparam logic [CNTW-1:0] CMAX = '1;

    logic [XLEN-1:0] regs    [NREG];
    logic [CNTW-1:0] cnt     [NREG];
    logic [CNTW-1:0] cnt_nxt [NREG];
    logic            any_nxt;
    logic            issue_hit;

    assign issue_ready = (cnt[issue_rd] != CMAX) || (issue_rd == '0);
    assign issue_hit   = issue_valid && issue_ready && !flush;

    // Net counter change per register, floored at zero; flush wins.
    always_comb begin
        int v;
        v       = 0;
        any_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) cnt_nxt[r] = '0;
        for (int r = 1; r < NREG; r++) begin
            v = int'(cnt[r]);
            if (issue_hit && issue_rd == AW'(r)) v = v + 1;
            for (int j = 0; j < NWP; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) v = v - 1;
            end
            if (v < 0 || flush) v = 0;
            cnt_nxt[r] = CNTW'(v);
            any_nxt    = any_nxt | (v != 0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            pend_any <= 1'b0;
        end else begin
            for (int j = 0; j < NWP; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            pend_any <= any_nxt;
        end
    end

    // Later write ports override earlier ones, matching the array update.
    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            hit;
        a        = '0;
        d        = '0;
        hit      = 1'b0;
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NRP; i++) begin
            a   = rd_addr[i*AW +: AW];
            d   = regs[a];
            hit = 1'b0;
            for (int j = 0; j < NWP; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                    hit = 1'b1;
                    if (BYPASS != 0) d = wr_data[j*XLEN +: XLEN];
                end
            end
            if (a == '0) d = '0;
            rd_data[i*XLEN +: XLEN] = d;
            rd_ready[i] = (cnt[a] == '0) ||
                          ((BYPASS != 0) && hit && cnt[a] == CNTW'(1));
        end
    end

endmodule
